spi_burst_arbiter: RTL and testbench

//   Shares one byte-level SPI master driver (start/ready handshake, 8-bit tx/rx) among
//   N_REQ requesters. Round-robin arbitration at burst granularity; a granted requester

---
 rtl/spi_burst_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_burst_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_arbiter.sv
// Shares one byte-level SPI master driver among N_REQ requesters: round-robin grant per burst,
// per-byte start/busy/done sequencing, rx byte return and abort of hung transfers.
module spi_burst_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 rsp_valid_o,
    output logic [2:0]           rsp_id_o,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_last_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 drv_start_o,
    output logic [7:0]           drv_data_o,
    input  logic                 drv_ready_i,
    input  logic [7:0]           drv_data_i
);

    localparam int unsigned IDW  = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 16;
    localparam int unsigned MAXR = 8;
    localparam int unsigned PW   = MAXR * DW;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4,
        S_HOLD      = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_grant;
    logic [IDW-1:0]     w_grant_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [DW-1:0]      w_rsp_data_nxt;

    logic [N_REQ-1:0]   r_req_ready;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [DW-1:0]      r_rsp_data;
    logic               r_rsp_last;
    logic               r_rsp_err;
    logic               r_busy;
    logic               r_drv_start;
    logic [DW-1:0]      r_drv_data;
    logic [DW-1:0]      w_drv_data_nxt;

    logic [MAXR-1:0]    w_valid_pad;
    logic [MAXR-1:0]    w_last_pad;
    logic [PW-1:0]      w_data_pad;
    logic [MAXR-1:0]    w_onehot;
    logic [3:0]         w_scan;
    logic [3:0]         w_ptr_inc;
    logic               w_arb_found;
    logic [IDW-1:0]     w_arb_idx;

    // Requester vectors widened to 8 entries so a 3-bit index is always in range.
    assign w_valid_pad = MAXR'(req_valid_i);
    assign w_last_pad  = MAXR'(req_last_i);
    assign w_data_pad  = PW'(req_data_i);
    assign w_onehot    = MAXR'(1) << w_grant_nxt;

    // Next-state, arbitration and datapath updates.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_ptr_nxt      = r_ptr;
        w_last_nxt     = r_last;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cnt;
        w_rsp_data_nxt = '0;
        w_drv_data_nxt = r_drv_data;
        w_arb_found    = 1'b0;
        w_arb_idx      = '0;
        w_scan         = '0;

        for (int i = 0; i < int'(N_REQ); i++) begin
            w_scan = 4'(r_ptr) + 4'(i);
            if (w_scan >= 4'(N_REQ)) begin
                w_scan = w_scan - 4'(N_REQ);
            end
            if (!w_arb_found && w_valid_pad[w_scan[2:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan[2:0];
            end
        end

        w_ptr_inc = 4'(r_grant) + 4'd1;
        if (w_ptr_inc >= 4'(N_REQ)) begin
            w_ptr_inc = 4'd0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_arb_found && drv_ready_i) begin
                    w_state_nxt = S_START;
                    w_grant_nxt = w_arb_idx;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_BUSY;
                w_cnt_nxt   = '0;
            end
            S_WAIT_BUSY: begin
                if (!drv_ready_i) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (drv_ready_i) begin
                    w_state_nxt    = S_RESP;
                    w_rsp_data_nxt = drv_data_i;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_state_nxt = S_RESP;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (r_last || r_err) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = IDW'(w_ptr_inc);
                end else if (w_valid_pad[r_grant]) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_valid_pad[r_grant]) begin
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Byte and last flag are taken while the requester still holds them, i.e. on entry to START.
        if (w_state_nxt == S_START) begin
            w_drv_data_nxt = w_data_pad[{w_grant_nxt, 3'b000} +: DW];
            w_last_nxt     = w_last_pad[w_grant_nxt];
            w_err_nxt      = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_drv_start <= 1'b0;
            r_drv_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_last      <= w_last_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_START) ? N_REQ'(w_onehot) : '0;
            r_drv_start <= (w_state_nxt == S_START);
            r_drv_data  <= w_drv_data_nxt;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_rsp_id    <= (w_state_nxt == S_RESP) ? w_grant_nxt : '0;
            r_rsp_data  <= (w_state_nxt == S_RESP) ? w_rsp_data_nxt : '0;
            r_rsp_last  <= (w_state_nxt == S_RESP) ? (w_last_nxt | w_err_nxt) : 1'b0;
            r_rsp_err   <= (w_state_nxt == S_RESP) ? w_err_nxt : 1'b0;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_last_o  = r_rsp_last;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = r_busy;
    assign drv_start_o = r_drv_start;
    assign drv_data_o  = r_drv_data;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter: queue-based requesters, a simple SPI driver model
// (rx = tx ^ 0x99) and an event log of grants and responses.
module tb_spi_burst_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        rsp_valid_o;
    logic [2:0]  rsp_id_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_last_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        drv_start_o;
    logic [7:0]  drv_data_o;
    logic        drv_ready_i;
    logic [7:0]  drv_data_i;

    spi_burst_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_last_o  (rsp_last_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .drv_start_o (drv_start_o),
        .drv_data_o  (drv_data_o),
        .drv_ready_i (drv_ready_i),
        .drv_data_i  (drv_data_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          hang = 1'b0;
    int          dly = 3;
    int          dcnt = 0;
    logic [7:0]  drx = 8'h00;

    logic [8:0]  rq [4][$];
    int          q_gnt [$];
    logic [7:0]  q_tx [$];
    logic [12:0] q_rsp [$];
    int          q_tstart [$];
    int          q_trsp [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor, requester queues and driver model, all sampled/driven on the falling edge.
    always @(negedge clk_i) begin
        cyc++;
        if (req_ready_o != 4'b0000) begin
            int gi;
            gi = 0;
            check("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
            check("start_with_ready", 32'(drv_start_o), 32'd1);
            for (int k = 0; k < 4; k++) if (req_ready_o[k]) gi = k;
            q_gnt.push_back(gi);
        end
        if (drv_start_o) begin
            q_tx.push_back(drv_data_o);
            q_tstart.push_back(cyc);
        end
        if (rsp_valid_o) begin
            q_rsp.push_back({rsp_id_o, rsp_data_o, rsp_last_o, rsp_err_o});
            q_trsp.push_back(cyc);
        end
        for (int k = 0; k < 4; k++) begin
            if (req_ready_o[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        end
        if (!rst_n_i) begin
            drv_ready_i = 1'b1;
            dcnt = 0;
        end else if (!hang && drv_start_o && drv_ready_i) begin
            drv_ready_i = 1'b0;
            dcnt = dly;
            drx = drv_data_o ^ 8'h99;
        end else if (!drv_ready_i) begin
            dcnt--;
            if (dcnt <= 0) begin
                drv_ready_i = 1'b1;
                drv_data_i = drx;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rq[k].size() > 0) begin
                req_valid_i[k]        = 1'b1;
                req_data_i[8*k +: 8]  = rq[k][0][7:0];
                req_last_i[k]         = rq[k][0][8];
            end else begin
                req_valid_i[k]        = 1'b0;
                req_data_i[8*k +: 8]  = 8'h00;
                req_last_i[k]         = 1'b0;
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d, input logic last);
        rq[k].push_back({last, d});
    endtask

    task automatic clr_logs();
        q_gnt.delete();
        q_tx.delete();
        q_rsp.delete();
        q_tstart.delete();
        q_trsp.delete();
    endtask

    function automatic bit all_empty();
        return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
    endfunction

    // Asserts reset on the current time step, checks outputs clear asynchronously, then releases.
    task automatic do_reset(input string tag);
        rst_n_i = 1'b0;
        for (int k = 0; k < 4; k++) rq[k].delete();
        #1;
        check(tag, 32'({req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_last_o, rsp_err_o,
                        busy_o, drv_start_o, drv_data_o}), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        clr_logs();
    endtask

    task automatic run_idle(input string tag, input int budget);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk_i);
            n++;
            if (!busy_o && drv_ready_i && all_empty()) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n;
        n = 0;
        while (q_tx.size() == 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_start"}, 32'(q_tx.size() > 0), 32'd1);
    endtask

    task automatic chk_gnt(input string tag, input int i, input int exp);
        check(tag, (i < q_gnt.size()) ? 32'(q_gnt[i]) : 32'hDEAD, 32'(exp));
    endtask

    task automatic chk_rsp(input string tag, input int i, input logic [2:0] id,
                           input logic [7:0] d, input logic last, input logic err);
        check(tag, (i < q_rsp.size()) ? 32'(q_rsp[i]) : 32'hFFFF, 32'({id, d, last, err}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i     = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        drv_ready_i = 1'b1;
        drv_data_i  = 8'h00;
        @(negedge clk_i);
        do_reset("t0_reset_outputs");

        // T1: single byte, rx echo 0xA5 ^ 0x99 = 0x3C.
        push(0, 8'hA5, 1'b1);
        run_idle("t1", 200);
        check("t1_ngnt", 32'(q_gnt.size()), 32'd1);
        chk_gnt("t1_gnt0", 0, 0);
        check("t1_tx", (q_tx.size() > 0) ? 32'(q_tx[0]) : 32'hDEAD, 32'h0A5);
        check("t1_nrsp", 32'(q_rsp.size()), 32'd1);
        chk_rsp("t1_rsp0", 0, 3'd0, 8'h3C, 1'b1, 1'b0);
        check("t1_busy", 32'(busy_o), 32'd0);

        // T2: simultaneous pairs from reset; pointer decides order.
        @(negedge clk_i);
        do_reset("t2_reset_outputs");
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        run_idle("t2a", 300);
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        run_idle("t2b", 300);
        chk_gnt("t2_gnt0", 0, 0);
        chk_gnt("t2_gnt1", 1, 1);
        chk_gnt("t2_gnt2", 2, 0);
        chk_gnt("t2_gnt3", 3, 1);
        chk_rsp("t2_rsp0", 0, 3'd0, 8'h88, 1'b1, 1'b0);
        chk_rsp("t2_rsp1", 1, 3'd1, 8'hBB, 1'b1, 1'b0);

        // T3: locked 3-byte burst on req0 while req1 waits.
        clr_logs();
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b1);
        push(1, 8'h44, 1'b1);
        run_idle("t3", 500);
        chk_gnt("t3_gnt0", 0, 0);
        chk_gnt("t3_gnt1", 1, 0);
        chk_gnt("t3_gnt2", 2, 0);
        chk_gnt("t3_gnt3", 3, 1);
        chk_rsp("t3_rsp0", 0, 3'd0, 8'h98, 1'b0, 1'b0);
        chk_rsp("t3_rsp1", 1, 3'd0, 8'h9B, 1'b0, 1'b0);
        chk_rsp("t3_rsp2", 2, 3'd0, 8'h9A, 1'b1, 1'b0);
        chk_rsp("t3_rsp3", 3, 3'd1, 8'hDD, 1'b1, 1'b0);

        // T3b: burst paused between bytes keeps the lock against req2.
        clr_logs();
        push(0, 8'h55, 1'b0);
        wait_start("t3b", 50);
        repeat (20) @(negedge clk_i);
        check("t3b_busy_hold", 32'(busy_o), 32'd1);
        check("t3b_nrsp_hold", 32'(q_rsp.size()), 32'd1);
        push(2, 8'h66, 1'b1);
        repeat (20) @(negedge clk_i);
        check("t3b_ngnt_hold", 32'(q_gnt.size()), 32'd1);
        push(0, 8'h77, 1'b1);
        run_idle("t3b", 300);
        chk_gnt("t3b_gnt1", 1, 0);
        chk_gnt("t3b_gnt2", 2, 2);
        chk_rsp("t3b_rsp0", 0, 3'd0, 8'hCC, 1'b0, 1'b0);
        chk_rsp("t3b_rsp1", 1, 3'd0, 8'hEE, 1'b1, 1'b0);
        chk_rsp("t3b_rsp2", 2, 3'd2, 8'hFF, 1'b1, 1'b0);

        // T4: driver never takes the byte; WAIT_BUSY starts one cycle after START, aborts 16 later.
        clr_logs();
        hang = 1'b1;
        push(1, 8'h12, 1'b1);
        run_idle("t4a", 300);
        hang = 1'b0;
        chk_rsp("t4_rsp_err", 0, 3'd1, 8'h00, 1'b1, 1'b1);
        check("t4_timeout_cycles",
              (q_trsp.size() > 0 && q_tstart.size() > 0) ? 32'(q_trsp[0] - q_tstart[0]) : 32'hDEAD,
              32'd17);
        push(3, 8'h34, 1'b1);
        run_idle("t4b", 300);
        chk_gnt("t4_gnt_next", 1, 3);
        chk_rsp("t4_rsp_next", 1, 3'd3, 8'hAD, 1'b1, 1'b0);

        // T5: reset while req1 sits in WAIT_DONE.
        clr_logs();
        dly = 8;
        push(1, 8'h5A, 1'b1);
        wait_start("t5", 50);
        repeat (3) @(negedge clk_i);
        check("t5_busy_before", 32'(busy_o), 32'd1);
        do_reset("t5_reset_outputs");
        dly = 3;
        repeat (15) @(negedge clk_i);
        check("t5_no_rsp", 32'(q_rsp.size()), 32'd0);
        push(0, 8'h0F, 1'b1);
        push(1, 8'hF0, 1'b1);
        run_idle("t5", 300);
        chk_gnt("t5_gnt0", 0, 0);
        chk_gnt("t5_gnt1", 1, 1);
        check("t5_nrsp", 32'(q_rsp.size()), 32'd2);
        chk_rsp("t5_rsp0", 0, 3'd0, 8'h96, 1'b1, 1'b0);
        chk_rsp("t5_rsp1", 1, 3'd1, 8'h69, 1'b1, 1'b0);

        // T6: all four valid with single-byte bursts, req0 has a second burst queued.
        @(negedge clk_i);
        do_reset("t6_reset_outputs");
        push(0, 8'h10, 1'b1);
        push(0, 8'h50, 1'b1);
        push(1, 8'h20, 1'b1);
        push(2, 8'h30, 1'b1);
        push(3, 8'h40, 1'b1);
        run_idle("t6", 600);
        chk_gnt("t6_gnt0", 0, 0);
        chk_gnt("t6_gnt1", 1, 1);
        chk_gnt("t6_gnt2", 2, 2);
        chk_gnt("t6_gnt3", 3, 3);
        chk_gnt("t6_gnt4", 4, 0);
        chk_rsp("t6_rsp0", 0, 3'd0, 8'h89, 1'b1, 1'b0);
        chk_rsp("t6_rsp1", 1, 3'd1, 8'hB9, 1'b1, 1'b0);
        chk_rsp("t6_rsp2", 2, 3'd2, 8'hA9, 1'b1, 1'b0);
        chk_rsp("t6_rsp3", 3, 3'd3, 8'hD9, 1'b1, 1'b0);
        chk_rsp("t6_rsp4", 4, 3'd0, 8'hC9, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
